multi_alarm_clock: RTL and testbench

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

---
 rtl/multi_alarm_clock.sv | 197 +++++++++++++++++++
 tb/tb_multi_alarm_clock.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour BCD clock with prescaler, multiple alarms, snooze and ring timeout
module multi_alarm_clock #(
    parameter int CLK_HZ     = 100000000,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 10,
    localparam int SW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            minute_in0,
    input  logic [3:0]            minute_in1,
    input  logic [3:0]            hour_in0,
    input  logic [1:0]            hour_in1,
    input  logic                  load_time,
    input  logic                  load_alarm,
    input  logic [SW-1:0]         alarm_sel,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    output logic [1:0]            hour_out1,
    output logic [3:0]            hour_out0,
    output logic [3:0]            minute_out1,
    output logic [3:0]            minute_out0,
    output logic [5:0]            seconds,
    output logic                  alarm,
    output logic [SW-1:0]         alarm_id,
    output logic                  snoozed
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic [1:0]    r_h1;
    logic [3:0]    r_h0, r_m1, r_m0;
    logic [13:0]   r_alm [NUM_ALARMS];
    state_t        r_state, w_state_nxt;
    logic [5:0]    r_cnt, w_cnt_nxt;
    logic [SW-1:0] r_id, w_id_nxt, w_hit_id;
    logic          r_alarm, r_snoozed;
    logic          w_tick, w_valid, w_load_t, w_roll, w_sel_ok, w_any;
    logic          w_m0_wrap, w_m1_wrap, w_h0_wrap, w_day_wrap;
    logic [3:0]    w_nm0, w_nm1, w_nh0;
    logic [1:0]    w_nh1;
    logic [13:0]   w_nxt;

    assign w_rst_n  = r_rst_sync[1];
    assign w_tick   = (r_presc == PW'(CLK_HZ - 1));
    assign w_valid  = (minute_in0 <= 4'd9) && (minute_in1 <= 4'd5) && (hour_in0 <= 4'd9) &&
                      ((hour_in1 < 2'd2) || ((hour_in1 == 2'd2) && (hour_in0 <= 4'd3)));
    assign w_load_t = load_time && w_valid;
    assign w_roll   = w_tick && (r_sec == 6'd59) && !w_load_t;
    assign w_sel_ok = 32'(alarm_sel) < NUM_ALARMS;

    assign hour_out1   = r_h1;
    assign hour_out0   = r_h0;
    assign minute_out1 = r_m1;
    assign minute_out0 = r_m0;
    assign seconds     = r_sec;
    assign alarm       = r_alarm;
    assign snoozed     = r_snoozed;
    assign alarm_id    = r_id;

    // Reset asserts immediately but is released only after two clean clock edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_rst_sync <= 2'b00;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    // Time of day one minute ahead, used both for the rollover update and alarm matching
    always_comb begin
        w_m0_wrap  = (r_m0 == 4'd9);
        w_m1_wrap  = w_m0_wrap && (r_m1 == 4'd5);
        w_h0_wrap  = w_m1_wrap && (r_h0 == 4'd9);
        w_day_wrap = w_m1_wrap && (r_h1 == 2'd2) && (r_h0 == 4'd3);
        w_nm0      = w_m0_wrap ? 4'd0 : r_m0 + 4'd1;
        w_nm1      = w_m1_wrap ? 4'd0 : (w_m0_wrap ? r_m1 + 4'd1 : r_m1);
        w_nh0      = (w_day_wrap || w_h0_wrap) ? 4'd0 : (w_m1_wrap ? r_h0 + 4'd1 : r_h0);
        w_nh1      = w_day_wrap ? 2'd0 : (w_h0_wrap ? r_h1 + 2'd1 : r_h1);
        w_nxt      = {w_nh1, w_nh0, w_nm1, w_nm0};
    end

    // Prescaler, seconds and BCD time; a valid load overrides any coincident tick
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_presc <= '0;
            r_sec   <= '0;
            r_h1    <= '0;
            r_h0    <= '0;
            r_m1    <= '0;
            r_m0    <= '0;
        end else if (w_load_t) begin
            r_presc <= '0;
            r_sec   <= '0;
            r_h1    <= hour_in1;
            r_h0    <= hour_in0;
            r_m1    <= minute_in1;
            r_m0    <= minute_in0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick)
                r_sec <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
            if (w_roll)
                {r_h1, r_h0, r_m1, r_m0} <= w_nxt;
        end
    end

    // Alarm time registers, written only from a valid BCD value and an in-range index
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++)
                r_alm[i] <= '0;
        end else if (load_alarm && w_valid && w_sel_ok) begin
            r_alm[alarm_sel] <= {hour_in1, hour_in0, minute_in1, minute_in0};
        end
    end

    // Lowest-index enabled alarm equal to the time a rollover is about to produce
    always_comb begin
        w_any    = 1'b0;
        w_hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (w_roll && alarm_en[i] && (r_alm[i] == w_nxt)) begin
                w_any    = 1'b1;
                w_hit_id = SW'(i);
            end
        end
    end

    // Ring/snooze next state, rollover counter and latched alarm index
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + {5'd0, w_roll};
        w_id_nxt    = r_id;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_any) begin
                    w_state_nxt = RINGING;
                    w_id_nxt    = w_hit_id;
                end
            end
            RINGING: begin
                if (stop_alarm) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (snooze) begin
                    w_state_nxt = SNOOZED;
                    w_cnt_nxt   = '0;
                end else if (w_roll && (r_cnt == 6'(RING_MIN - 1))) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            SNOOZED: begin
                if (stop_alarm) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_any) begin
                    w_state_nxt = RINGING;
                    w_cnt_nxt   = '0;
                    w_id_nxt    = w_hit_id;
                end else if (w_roll && (r_cnt == 6'(SNOOZE_MIN - 1))) begin
                    w_state_nxt = RINGING;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register with registered status outputs
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_id      <= '0;
            r_alarm   <= 1'b0;
            r_snoozed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_id      <= w_id_nxt;
            r_alarm   <= (w_state_nxt == RINGING);
            r_snoozed <= (w_state_nxt == SNOOZED);
        end
    end
endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock: directed scenarios checked against a minute-of-day behavioural model
module tb_multi_alarm_clock;
    localparam int HZ = 10;
    localparam int NA = 4;
    localparam int SN = 2;
    localparam int RG = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] minute_in0 = '0, minute_in1 = '0, hour_in0 = '0;
    logic [1:0] hour_in1 = '0;
    logic       load_time = 1'b0, load_alarm = 1'b0, stop_alarm = 1'b0, snooze = 1'b0;
    logic [1:0] alarm_sel = '0;
    logic [3:0] alarm_en = '0;
    logic [1:0] hour_out1;
    logic [3:0] hour_out0, minute_out1, minute_out0;
    logic [5:0] seconds;
    logic       alarm, snoozed;
    logic [1:0] alarm_id;

    int checks = 0;
    int failures = 0;

    int m_rs, m_presc, m_sec, m_tod, m_st, m_cnt, m_id;
    int m_alm [NA];

    multi_alarm_clock #(.CLK_HZ(HZ), .NUM_ALARMS(NA), .SNOOZE_MIN(SN), .RING_MIN(RG)) dut (
        .clk(clk), .reset(reset),
        .minute_in0(minute_in0), .minute_in1(minute_in1), .hour_in0(hour_in0), .hour_in1(hour_in1),
        .load_time(load_time), .load_alarm(load_alarm), .alarm_sel(alarm_sel), .alarm_en(alarm_en),
        .stop_alarm(stop_alarm), .snooze(snooze),
        .hour_out1(hour_out1), .hour_out0(hour_out0), .minute_out1(minute_out1), .minute_out0(minute_out0),
        .seconds(seconds), .alarm(alarm), .alarm_id(alarm_id), .snoozed(snoozed)
    );

    always #5 clk = ~clk;

    task automatic m_clear();
        m_presc = 0; m_sec = 0; m_tod = 0; m_st = 0; m_cnt = 0; m_id = 0;
        for (int i = 0; i < NA; i++) m_alm[i] = 0;
    endtask

    // One clock of the model: st 0=idle, 1=ringing, 2=snoozed; time kept as minutes since midnight
    task automatic m_step();
        int h, mn, nt, hit;
        bit vt, lt, tick, roll;
        h    = int'(hour_in1) * 10 + int'(hour_in0);
        mn   = int'(minute_in1) * 10 + int'(minute_in0);
        vt   = (minute_in0 <= 9) && (minute_in1 <= 5) && (hour_in0 <= 9) && (h <= 23);
        lt   = load_time && vt;
        tick = (m_presc == HZ - 1);
        roll = tick && (m_sec == 59) && !lt;
        nt   = (m_tod + 1) % 1440;
        hit  = -1;
        if (roll)
            for (int i = 0; i < NA; i++)
                if (hit < 0 && alarm_en[i] && m_alm[i] == nt) hit = i;
        case (m_st)
            0: if (hit >= 0) begin m_st = 1; m_cnt = 0; m_id = hit; end
            1: begin
                if (stop_alarm) m_st = 0;
                else if (snooze) begin m_st = 2; m_cnt = 0; end
                else if (roll) begin m_cnt++; if (m_cnt == RG) m_st = 0; end
            end
            default: begin
                if (stop_alarm) m_st = 0;
                else if (hit >= 0) begin m_st = 1; m_cnt = 0; m_id = hit; end
                else if (roll) begin m_cnt++; if (m_cnt == SN) begin m_st = 1; m_cnt = 0; end end
            end
        endcase
        if (load_alarm && vt && alarm_sel < NA) m_alm[alarm_sel] = h * 60 + mn;
        if (lt) begin
            m_tod = h * 60 + mn; m_sec = 0; m_presc = 0;
        end else if (tick) begin
            m_presc = 0;
            m_sec = (m_sec + 1) % 60;
            if (roll) m_tod = nt;
        end else begin
            m_presc++;
        end
    endtask

    // Model clock, including the two-edge delay before reset release takes effect
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rs = 0;
            m_clear();
        end else if (m_rs < 2) begin
            m_rs++;
        end else begin
            m_step();
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [23:0] got, exp;
        int hh, mm;
        hh  = m_tod / 60;
        mm  = m_tod % 60;
        got = {hour_out1, hour_out0, minute_out1, minute_out0, seconds, alarm, alarm_id, snoozed};
        exp = {2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 6'(m_sec), m_st == 1, 2'(m_id), m_st == 2};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got, exp);
        end
    end

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic int dut_hhmm();
        return (int'(hour_out1) * 10 + int'(hour_out0)) * 100 + int'(minute_out1) * 10 + int'(minute_out0);
    endfunction

    task automatic ld_raw(int h1, int h0, int m1, int m0);
        @(negedge clk);
        hour_in1 = 2'(h1); hour_in0 = 4'(h0); minute_in1 = 4'(m1); minute_in0 = 4'(m0);
        load_time = 1'b1;
        @(negedge clk);
        load_time = 1'b0;
    endtask

    task automatic ld_time(int hh, int mm);
        ld_raw(hh / 10, hh % 10, mm / 10, mm % 10);
    endtask

    task automatic ld_alarm(int sel, int hh, int mm);
        @(negedge clk);
        alarm_sel = 2'(sel);
        hour_in1 = 2'(hh / 10); hour_in0 = 4'(hh % 10); minute_in1 = 4'(mm / 10); minute_in0 = 4'(mm % 10);
        load_alarm = 1'b1;
        @(negedge clk);
        load_alarm = 1'b0;
    endtask

    task automatic pulse(bit st, bit sz);
        @(negedge clk);
        stop_alarm = st; snooze = sz;
        @(negedge clk);
        stop_alarm = 1'b0; snooze = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_time", dut_hhmm() * 100 + int'(seconds), 0);
        chk("reset_alarm", int'(alarm), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (5) @(negedge clk);

        ld_time(23, 59);
        repeat (599) @(negedge clk);
        chk("pre_wrap", dut_hhmm() * 100 + int'(seconds), 235959);
        repeat (1) @(negedge clk);
        chk("day_wrap", dut_hhmm() * 100 + int'(seconds), 0);

        ld_alarm(1, 7, 0);
        ld_alarm(0, 8, 0);
        alarm_en = 4'b0010;
        ld_time(6, 59);
        repeat (599) @(negedge clk);
        chk("no_ring_early", int'(alarm), 0);
        repeat (1) @(negedge clk);
        chk("ring1", int'(alarm), 1);
        chk("ring1_id", int'(alarm_id), 1);
        chk("ring1_time", dut_hhmm(), 700);
        alarm_en = 4'b0000;
        repeat (5) @(negedge clk);
        chk("en_drop_keeps_ring", int'(alarm), 1);
        pulse(1'b1, 1'b0);
        chk("stop", int'(alarm), 0);

        alarm_en = 4'b0011;
        ld_alarm(0, 7, 0);
        ld_time(6, 59);
        repeat (600) @(negedge clk);
        chk("ring0_id", int'(alarm_id), 0);
        chk("ring0", int'(alarm), 1);
        pulse(1'b0, 1'b1);
        chk("snooze_alarm", int'(alarm), 0);
        chk("snooze_flag", int'(snoozed), 1);
        repeat (1197) @(negedge clk);
        chk("still_snoozed", int'(snoozed), 1);
        repeat (1) @(negedge clk);
        chk("rering", int'(alarm), 1);
        chk("rering_id", int'(alarm_id), 0);
        pulse(1'b1, 1'b0);
        chk("stop_after_rering", int'(alarm), 0);

        ld_time(6, 59);
        repeat (600) @(negedge clk);
        chk("ring_timeout_start", int'(alarm), 1);
        repeat (1799) @(negedge clk);
        chk("ring_before_timeout", int'(alarm), 1);
        repeat (1) @(negedge clk);
        chk("ring_timeout", int'(alarm), 0);
        chk("timeout_time", dut_hhmm(), 703);

        ld_raw(1, 2, 6, 0);
        chk("bad_minute_ignored", dut_hhmm(), 703);
        ld_raw(2, 4, 0, 0);
        chk("bad_hour_ignored", dut_hhmm(), 703);
        ld_time(7, 0);
        repeat (3) @(negedge clk);
        chk("load_onto_alarm_time", dut_hhmm(), 700);
        chk("load_no_ring", int'(alarm), 0);
        repeat (597) @(negedge clk);
        chk("after_load_minute", dut_hhmm(), 701);

        ld_time(6, 59);
        repeat (600) @(negedge clk);
        chk("ring_for_stop_snz", int'(alarm), 1);
        pulse(1'b1, 1'b1);
        chk("stop_wins_alarm", int'(alarm), 0);
        chk("stop_wins_snoozed", int'(snoozed), 0);
        pulse(1'b0, 1'b1);
        chk("idle_snooze_ignored", int'(snoozed), 0);

        alarm_en = 4'b0010;
        ld_time(6, 59);
        repeat (600) @(negedge clk);
        chk("ring_id1", int'(alarm_id), 1);
        pulse(1'b0, 1'b1);
        chk("snoozed_before_reset", int'(snoozed), 1);
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_time", dut_hhmm() * 100 + int'(seconds), 0);
        chk("rst_flags", int'({alarm, snoozed, alarm_id}), 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_reset_idle", int'({alarm, snoozed}), 0);
        chk("post_reset_time", dut_hhmm(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
